// File: rtl/pipelined_dot_product.sv
// Streaming three-stage inner-product engine: operand register, product register, accumulator.
// One result per VEC_LEN accepted element pairs; clr aborts the vector in flight.
module pipelined_dot_product #(
  parameter int W       = 8,
  parameter int VEC_LEN = 4,
  parameter int SIGNED  = 0,
  parameter int ACC_W   = 2*W + $clog2(VEC_LEN),
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] elem_idx,
  output logic             busy
);

  logic [IDX_W-1:0] idx_r;
  logic             accept_s;
  logic             first_s;
  logic             last_s;

  logic [W-1:0]     s1_a_r;
  logic [W-1:0]     s1_b_r;
  logic             s1_valid_r;
  logic             s1_first_r;
  logic             s1_last_r;

  logic [2*W-1:0]   prod_s;
  logic [2*W-1:0]   s2_p_r;
  logic             s2_valid_r;
  logic             s2_first_r;
  logic             s2_last_r;

  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic [ACC_W-1:0] acc_r;
  logic             s3_valid_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_data_r;

  assign accept_s = in_valid & ~clr;
  assign first_s  = (idx_r == IDX_W'(0));
  assign last_s   = (idx_r == IDX_W'(VEC_LEN - 1));

  // Element index: counts accepted pairs, wraps after the last element of a vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= IDX_W'(0);
    end else if (clr) begin
      idx_r <= IDX_W'(0);
    end else if (in_valid) begin
      idx_r <= last_s ? IDX_W'(0) : idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Stage 1: capture operands and first/last framing tags on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_r     <= W'(0);
      s1_b_r     <= W'(0);
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r     <= in_a;
        s1_b_r     <= in_b;
        s1_first_r <= first_s;
        s1_last_r  <= last_s;
      end else begin
        s1_a_r     <= s1_a_r;
        s1_b_r     <= s1_b_r;
        s1_first_r <= s1_first_r;
        s1_last_r  <= s1_last_r;
      end
    end
  end

  // Operands are widened to 2*W first so the product is exact in either signedness.
  generate
    if (SIGNED != 0) begin : g_signed
      assign prod_s     = $signed({{W{s1_a_r[W-1]}}, s1_a_r}) * $signed({{W{s1_b_r[W-1]}}, s1_b_r});
      assign prod_ext_s = ACC_W'($signed(s2_p_r));
    end else begin : g_unsigned
      assign prod_s     = {{W{1'b0}}, s1_a_r} * {{W{1'b0}}, s1_b_r};
      assign prod_ext_s = ACC_W'(s2_p_r);
    end
  endgenerate

  // Stage 2: product register, carries the framing tags along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_p_r     <= {(2*W){1'b0}};
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
    end else if (clr) begin
      s2_p_r     <= s2_p_r;
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_p_r     <= prod_s;
        s2_first_r <= s1_first_r;
        s2_last_r  <= s1_last_r;
      end else begin
        s2_p_r     <= s2_p_r;
        s2_first_r <= s2_first_r;
        s2_last_r  <= s2_last_r;
      end
    end
  end

  // The first tag restarts the sum so consecutive vectors never mix.
  assign sum_s = s2_first_r ? prod_ext_s : (acc_r + prod_ext_s);

  // Stage 3: accumulator and result register; clr suppresses a result landing this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= ACC_W'(0);
      s3_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= ACC_W'(0);
    end else if (clr) begin
      acc_r       <= ACC_W'(0);
      s3_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      s3_valid_r  <= s2_valid_r;
      out_valid_r <= s2_valid_r & s2_last_r;
      if (s2_valid_r) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (s2_valid_r && s2_last_r) begin
        out_data_r <= sum_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign elem_idx  = idx_r;
  assign busy      = (idx_r != IDX_W'(0)) | s1_valid_r | s2_valid_r | s3_valid_r;

endmodule

// File: tb/tb_pipelined_dot_product.sv
// Directed bench: unsigned and signed instances share one stimulus stream; a reference
// model pushes expected results with their due cycle and a monitor pops and compares them.
module tb_pipelined_dot_product;

  typedef logic signed [63:0] val_t;
  typedef struct {
    val_t val;
    int   due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;

  logic        out_valid_u, out_valid_s;
  logic [17:0] out_data_u, out_data_s;
  logic [1:0]  elem_idx_u, elem_idx_s;
  logic        busy_u, busy_s;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idx_m = 0;
  logic [2:0] hist = 3'b000;
  val_t sum_u = 0;
  val_t sum_s = 0;
  val_t last_u = 0;
  val_t last_s = 0;
  exp_t qu[$];
  exp_t qs[$];
  exp_t eu, es;

  pipelined_dot_product #(.W(8), .VEC_LEN(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_u), .out_data(out_data_u), .elem_idx(elem_idx_u), .busy(busy_u)
  );

  pipelined_dot_product #(.W(8), .VEC_LEN(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_s), .out_data(out_data_s), .elem_idx(elem_idx_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input val_t obs, input val_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; check index/busy against the model first.
  task automatic drive(input bit v, input bit c, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    val_t pu, ps;
    @(negedge clk);
    check("elem_idx_u", val_t'(elem_idx_u), val_t'(idx_m));
    check("elem_idx_s", val_t'(elem_idx_s), val_t'(idx_m));
    check("busy_u", val_t'(busy_u), val_t'((idx_m != 0) || (hist != 3'b000)));
    check("busy_s", val_t'(busy_s), val_t'((idx_m != 0) || (hist != 3'b000)));
    in_valid = v;
    clr = c;
    in_a = a;
    in_b = b;
    acc = v && !c;
    if (c) begin
      idx_m = 0;
      hist = 3'b000;
      qu.delete();
      qs.delete();
    end else begin
      hist = {hist[1:0], acc};
      if (acc) begin
        pu = val_t'(a) * val_t'(b);
        ps = val_t'($signed(a)) * val_t'($signed(b));
        sum_u = (idx_m == 0) ? pu : sum_u + pu;
        sum_s = (idx_m == 0) ? ps : sum_s + ps;
        if (idx_m == 3) begin
          qu.push_back('{val: sum_u, due: cyc + 3});
          qs.push_back('{val: sum_s, due: cyc + 3});
          idx_m = 0;
        end else begin
          idx_m = idx_m + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic vec(input logic [7:0] a0, a1, a2, a3, input logic [7:0] b0, b1, b2, b3);
    drive(1'b1, 1'b0, a0, b0);
    drive(1'b1, 1'b0, a1, b1);
    drive(1'b1, 1'b0, a2, b2);
    drive(1'b1, 1'b0, a3, b3);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid_u", val_t'(out_valid_u), 0);
    check("rst_out_data_u", val_t'(out_data_u), 0);
    check("rst_elem_idx_u", val_t'(elem_idx_u), 0);
    check("rst_busy_u", val_t'(busy_u), 0);
    check("rst_out_valid_s", val_t'(out_valid_s), 0);
    check("rst_out_data_s", val_t'($signed(out_data_s)), 0);
    check("rst_busy_s", val_t'(busy_s), 0);
  endtask

  // Scoreboard monitor for the unsigned instance, sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid_u) begin
        if (qu.size() == 0) begin
          check("spurious_pulse_u", val_t'(out_valid_u), 0);
        end else begin
          eu = qu.pop_front();
          check("out_data_u", val_t'(out_data_u), eu.val);
          check("pulse_cycle_u", val_t'(cyc), val_t'(eu.due));
          last_u = eu.val;
        end
      end else if (qu.size() != 0 && qu[0].due <= cyc) begin
        check("missing_pulse_u", val_t'(out_valid_u), 1);
        void'(qu.pop_front());
      end
    end
  end

  // Scoreboard monitor for the signed instance.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid_s) begin
        if (qs.size() == 0) begin
          check("spurious_pulse_s", val_t'(out_valid_s), 0);
        end else begin
          es = qs.pop_front();
          check("out_data_s", val_t'($signed(out_data_s)), es.val);
          check("pulse_cycle_s", val_t'(cyc), val_t'(es.due));
          last_s = es.val;
        end
      end else if (qs.size() != 0 && qs[0].due <= cyc) begin
        check("missing_pulse_s", val_t'(out_valid_s), 1);
        void'(qs.pop_front());
      end
    end
  end

  initial begin
    #3;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vector 1..4 squared -> 30, then let the pipeline drain.
    vec(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4);
    idle(4);
    check("basic_hold_u", val_t'(out_data_u), 30);

    // Gapless counter stream -> 14, 126, 366 four cycles apart.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(i), 8'(i));
    idle(4);
    check("stream_last_u", val_t'(out_data_u), 366);

    // Extreme operands back to back.
    vec(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    vec(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    vec(8'd128, 8'd128, 8'd128, 8'd128, 8'd127, 8'd127, 8'd127, 8'd127);
    idle(4);
    check("neg_extreme_s", val_t'($signed(out_data_s)), -65024);
    check("neg_extreme_u", val_t'(out_data_u), 65024);

    // Bubbles of 0, 3 and 1 idle cycles inside the vector.
    drive(1'b1, 1'b0, 8'd1, 8'd1);
    drive(1'b1, 1'b0, 8'd2, 8'd2);
    idle(3);
    drive(1'b1, 1'b0, 8'd3, 8'd3);
    idle(1);
    drive(1'b1, 1'b0, 8'd4, 8'd4);
    idle(4);
    check("bubble_u", val_t'(out_data_u), 30);

    // Abort one edge after the last element: no result, previous data held.
    vec(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    drive(1'b0, 1'b1, 8'd9, 8'd9);
    idle(4);
    check("clr_hold_u", val_t'(out_data_u), last_u);
    check("clr_hold_s", val_t'($signed(out_data_s)), last_s);
    vec(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    idle(4);
    check("after_clr_u", val_t'(out_data_u), 4);

    // Abort after two elements; the clr-edge pair must be discarded too.
    drive(1'b1, 1'b0, 8'd7, 8'd7);
    drive(1'b1, 1'b0, 8'd7, 8'd7);
    drive(1'b1, 1'b1, 8'd7, 8'd7);
    idle(1);
    check("clr_idx_u", val_t'(elem_idx_u), 0);
    idle(3);

    // Asynchronous reset mid-vector, away from any clock edge.
    drive(1'b1, 1'b0, 8'd9, 8'd9);
    drive(1'b1, 1'b0, 8'd9, 8'd9);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    idx_m = 0;
    hist = 3'b000;
    last_u = 0;
    last_s = 0;
    qu.delete();
    qs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    vec(8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3);
    idle(5);
    check("post_reset_u", val_t'(out_data_u), 24);
    check("post_reset_s", val_t'($signed(out_data_s)), 24);
    check("drain_u", val_t'(qu.size()), 0);
    check("drain_s", val_t'(qs.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
